// File: rtl/calc_core.sv
// calc_core: calculator arithmetic core.
// Takes key events from the keyboard scanner and does digit entry, left-to-right
// chained + - * on unsigned integers 0..MAX_VAL, and error handling.
// Multiplication is a sequential shift-add that takes WIDTH cycles.
// Handshake: the scanner holds intro high while a key is down, and each rising edge
// of intro is one key event. value is sampled in that cycle. The core answers with a
// one-cycle convert strobe, and num/error are valid in that same cycle.
module calc_core #(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       value,
  input  logic             intro,
  output logic [WIDTH-1:0] num,
  output logic             convert,
  output logic             error,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_MUL  = 2'd3;
  localparam logic [1:0] OP_SUB  = 2'd2;

  localparam logic [3:0] KEY_EQ = 4'd13;
  localparam logic [3:0] KEY_AC = 4'd15;

  localparam logic [WIDTH+3:0]   MAX_X     = (WIDTH+4)'(MAX_VAL);
  localparam logic [WIDTH:0]     MAX_S     = (WIDTH+1)'(MAX_VAL);
  localparam logic [2*WIDTH-1:0] MAX_P     = (2*WIDTH)'(MAX_VAL);
  localparam logic [CW-1:0]      LAST_STEP = CW'(WIDTH-1);

  logic [1:0]         r_state, r_op, r_pend_op;
  logic [WIDTH-1:0]   r_acc, r_entry, r_num, r_mplier;
  logic [2*WIDTH-1:0] r_mcand, r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_ev, r_rh, r_intro_q, r_init, r_convert, r_error, r_busy;

  logic               w_key, w_is_digit, w_is_oper, w_is_eq;
  logic [3:0]         w_op_code;
  logic [1:0]         w_new_op;
  logic [WIDTH-1:0]   w_value_w;
  logic [WIDTH+3:0]   w_entry_ext, w_digit_x;
  logic [WIDTH:0]     w_sum;
  logic               w_arith_err;
  logic [WIDTH-1:0]   w_arith_val;
  logic [2*WIDTH-1:0] w_prod_next;
  logic               w_mul_done, w_eval_now, w_finish;
  logic               w_fin_err;
  logic [WIDTH-1:0]   w_fin_val;
  logic [1:0]         w_fin_pend;

  // Key decode. intro_q resets high, so a key held through reset is not an event.
  assign w_key      = intro & ~r_intro_q;
  assign w_is_digit = (value <= 4'd9);
  assign w_is_oper  = (value >= 4'd10) && (value <= 4'd12);
  assign w_is_eq    = (value == KEY_EQ);
  assign w_op_code  = value - 4'd9;
  assign w_new_op   = w_op_code[1:0];
  assign w_value_w  = {{(WIDTH-4){1'b0}}, value};

  // Digit append: entry*10 + d, computed with headroom for the overflow test.
  assign w_entry_ext = {4'b0000, r_entry};
  assign w_digit_x   = (w_entry_ext << 3) + (w_entry_ext << 1) + {{WIDTH{1'b0}}, value};

  // Single-cycle add/sub evaluation with range checks.
  assign w_sum       = {1'b0, r_acc} + {1'b0, r_entry};
  assign w_arith_err = (r_op == OP_SUB) ? (r_acc < r_entry) : (w_sum > MAX_S);
  assign w_arith_val = (r_op == OP_SUB) ? (r_acc - r_entry) : w_sum[WIDTH-1:0];

  // One shift-add step; the last step is used directly to produce the result.
  assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  // A result is produced either by the last multiply step or by an add/sub evaluation.
  assign w_mul_done = (r_state == ST_MUL) && (r_cnt == LAST_STEP);
  assign w_eval_now = (r_state == ST_IDLE) && w_key && (w_is_oper || w_is_eq) &&
                      (r_op != OP_NONE) && r_ev;
  assign w_finish   = w_mul_done || (w_eval_now && (r_op != OP_MUL));
  assign w_fin_err  = (r_state == ST_MUL) ? (w_prod_next > MAX_P) : w_arith_err;
  assign w_fin_val  = (r_state == ST_MUL) ? w_prod_next[WIDTH-1:0] : w_arith_val;
  assign w_fin_pend = (r_state == ST_MUL) ? r_pend_op : (w_is_eq ? OP_NONE : w_new_op);

  // Main control: key handling, multiply sequencing and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NONE;
      r_pend_op <= OP_NONE;
      r_acc     <= '0;
      r_entry   <= '0;
      r_num     <= '0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_ev      <= 1'b0;
      r_rh      <= 1'b0;
      r_intro_q <= 1'b1;
      r_init    <= 1'b1;
      r_convert <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_intro_q <= intro;
      r_convert <= 1'b0;
      r_init    <= 1'b0;
      if (r_init) begin
        // first edge after reset: tell the display to show 0
        r_convert <= 1'b1;
        r_num     <= '0;
      end else if (w_key && (value == KEY_AC)) begin
        r_state   <= ST_IDLE;
        r_op      <= OP_NONE;
        r_pend_op <= OP_NONE;
        r_acc     <= '0;
        r_entry   <= '0;
        r_num     <= '0;
        r_mplier  <= '0;
        r_mcand   <= '0;
        r_prod    <= '0;
        r_cnt     <= '0;
        r_ev      <= 1'b0;
        r_rh      <= 1'b0;
        r_error   <= 1'b0;
        r_busy    <= 1'b0;
        r_convert <= 1'b1;
      end else if (w_finish) begin
        r_busy    <= 1'b0;
        r_convert <= 1'b1;
        if (w_fin_err) begin
          r_state <= ST_ERR;
          r_error <= 1'b1;
          r_num   <= '0;
        end else begin
          r_state <= ST_IDLE;
          r_acc   <= w_fin_val;
          r_num   <= w_fin_val;
          r_op    <= w_fin_pend;
          r_rh    <= (w_fin_pend == OP_NONE);
          r_entry <= '0;
          r_ev    <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_key) begin
              if (w_is_digit) begin
                if (r_rh) begin
                  r_entry   <= w_value_w;
                  r_acc     <= '0;
                  r_rh      <= 1'b0;
                  r_ev      <= 1'b1;
                  r_num     <= w_value_w;
                  r_convert <= 1'b1;
                end else if (w_digit_x <= MAX_X) begin
                  r_entry   <= w_digit_x[WIDTH-1:0];
                  r_ev      <= 1'b1;
                  r_num     <= w_digit_x[WIDTH-1:0];
                  r_convert <= 1'b1;
                end
              end else if (w_is_oper || w_is_eq) begin
                if (w_eval_now) begin
                  // only a pending multiply reaches here; add/sub finished above
                  r_mcand   <= {{WIDTH{1'b0}}, r_acc};
                  r_mplier  <= r_entry;
                  r_prod    <= '0;
                  r_cnt     <= '0;
                  r_pend_op <= w_is_eq ? OP_NONE : w_new_op;
                  r_state   <= ST_MUL;
                  r_busy    <= 1'b1;
                end else if (w_is_eq) begin
                  r_convert <= 1'b1;
                end else begin
                  if ((r_op == OP_NONE) && !r_rh) begin
                    r_acc <= r_entry;
                    r_num <= r_entry;
                  end else begin
                    r_num <= r_acc;
                  end
                  r_op      <= w_new_op;
                  r_entry   <= '0;
                  r_ev      <= 1'b0;
                  r_rh      <= 1'b0;
                  r_convert <= 1'b1;
                end
              end else begin
                // clear entry: accumulator and pending operator survive
                r_entry   <= '0;
                r_ev      <= 1'b0;
                r_num     <= '0;
                r_convert <= 1'b1;
              end
            end
          end
          ST_MUL: begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign num       = r_num;
  assign convert   = r_convert;
  assign error     = r_error;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: key-level bench for calc_core with a behavioural calculator model.
module tb_calc_core;
  localparam int WIDTH   = 14;
  localparam int MAX_VAL = 9999;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       value;
  logic             intro;
  logic [WIDTH-1:0] num;
  logic             convert, error, busy;
  logic [1:0]       dbg_state;

  calc_core #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .intro(intro),
    .num(num), .convert(convert), .error(error), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: expected and observed {error,num} per convert strobe
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] obs_q[$];
  int             busy_cnt  = 0;
  logic           prev_conv = 1'b0;
  logic           prev_rst  = 1'b0;
  logic [WIDTH-1:0] prev_num = '0;

  always @(negedge clk) begin
    if (rst_n && convert) obs_q.push_back({error, num});
    if (rst_n && prev_rst) begin
      if (convert) check_eq("conv_gap", int'(prev_conv), 0);
      else         check_eq("num_hold", int'(num), int'(prev_num));
    end
    if (busy) busy_cnt++;
    prev_conv = convert;
    prev_num  = num;
    prev_rst  = rst_n;
  end

  task automatic compare_q(input string tag);
    logic [WIDTH:0] e, o;
    check_eq({tag, "_nconv"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_eq({tag, "_num"}, int'(o[WIDTH-1:0]), int'(e[WIDTH-1:0]));
      check_eq({tag, "_err"}, int'(o[WIDTH]), int'(e[WIDTH]));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // behavioural calculator: plain integers, one call per key press
  int m_acc, m_entry, m_op, m_num;
  bit m_ev, m_rh, m_err;

  task automatic model_reset();
    m_acc = 0; m_entry = 0; m_op = 0; m_num = 0;
    m_ev = 0; m_rh = 0; m_err = 0;
  endtask

  task automatic model_key(input int k, output bit c, output int word, output int exp_busy);
    int r;
    c = 0; word = 0; exp_busy = 0;
    if (k == 15) begin
      model_reset();
      c = 1;
    end else if (m_err) begin
      c = 0;
    end else if (k <= 9) begin
      if (m_rh) begin
        m_entry = k; m_acc = 0; m_rh = 0; m_ev = 1; m_num = k; c = 1;
      end else if (m_entry * 10 + k <= MAX_VAL) begin
        m_entry = m_entry * 10 + k; m_ev = 1; m_num = m_entry; c = 1;
      end
    end else if (k == 14) begin
      m_entry = 0; m_ev = 0; m_num = 0; c = 1;
    end else if (m_op != 0 && m_ev) begin
      if (m_op == 1)      r = m_acc + m_entry;
      else if (m_op == 2) r = m_acc - m_entry;
      else begin
        r = m_acc * m_entry;
        exp_busy = WIDTH;
      end
      c = 1;
      if (r < 0 || r > MAX_VAL) begin
        m_err = 1; m_num = 0;
      end else begin
        m_acc = r; m_num = r;
        m_op = (k == 13) ? 0 : k - 9;
        m_rh = (k == 13);
        m_entry = 0; m_ev = 0;
      end
    end else if (k == 13) begin
      c = 1;
    end else begin
      if (m_op == 0 && !m_rh) m_acc = m_entry;
      m_num = m_acc; m_op = k - 9; m_entry = 0; m_ev = 0; m_rh = 0; c = 1;
    end
    if (c) word = (int'(m_err) << WIDTH) | m_num;
  endtask

  // driver: one key press, then wait long enough for any multiply to finish
  task automatic press(input int k);
    bit c; int word, eb, b0;
    logic [31:0] wv;
    model_key(k, c, word, eb);
    wv = word;
    if (c) exp_q.push_back(wv[WIDTH:0]);
    b0 = busy_cnt;
    @(negedge clk); value = 4'(k); intro = 1'b1;
    repeat (2) @(negedge clk);
    intro = 1'b0; value = 4'($urandom_range(0, 15));
    repeat (WIDTH + 3) @(negedge clk);
    check_eq("busy_len", busy_cnt - b0, eb);
    compare_q($sformatf("key%0d", k));
  endtask

  task automatic press_seq(input int keys[]);
    foreach (keys[i]) press(keys[i]);
  endtask

  initial begin
    bit c; int word, eb, b0, r;
    logic [31:0] wv;
    rst_n = 1'b0; intro = 1'b0; value = 4'd0;
    model_reset();

    // reset held 5 cycles, outputs quiet, then one convert with num = 0
    repeat (5) begin
      @(negedge clk);
      check_eq("rst_num", int'(num), 0);
      check_eq("rst_conv", int'(convert), 0);
      check_eq("rst_err", int'(error), 0);
      check_eq("rst_busy", int'(busy), 0);
    end
    exp_q.push_back('0);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compare_q("post_rst");

    press_seq('{1, 2, 10, 3, 4, 13});
    check_eq("sum_46", int'(num), 46);
    press_seq('{2, 10, 3, 12, 4, 13});
    check_eq("chain_20", int'(num), 20);
    check_eq("chain_err", int'(error), 0);

    press(15);
    press_seq('{9, 9, 9, 9, 9});
    check_eq("cap_9999", int'(num), 9999);
    press(14);
    check_eq("ce_0", int'(num), 0);

    // multiply with a key pressed while busy
    press(15);
    press_seq('{1, 2, 3, 12, 4, 5});
    model_key(13, c, word, eb);
    wv = word;
    exp_q.push_back(wv[WIDTH:0]);
    b0 = busy_cnt;
    @(negedge clk); value = 4'd13; intro = 1'b1;
    repeat (2) @(negedge clk); intro = 1'b0;
    repeat (2) @(negedge clk); value = 4'd7; intro = 1'b1;
    repeat (2) @(negedge clk); intro = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);
    check_eq("mul_busy", busy_cnt - b0, WIDTH);
    compare_q("mul_eq");
    check_eq("mul_5535", int'(num), 5535);

    // error cases, each recovered by AC
    press(15);
    press_seq('{5, 11, 7, 13});
    check_eq("sub_err", int'(error), 1);
    press(3);
    press(15);
    check_eq("ac_clr", int'(error), 0);
    press_seq('{9, 9, 9, 9, 10, 1, 13});
    check_eq("add_err", int'(error), 1);
    press(15);
    press_seq('{1, 0, 0, 12, 1, 0, 0, 13});
    check_eq("mul_err", int'(error), 1);
    check_eq("mul_err_num", int'(num), 0);
    press(15);

    // randomized key stream
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (m_err && r < 40)  press(15);
      else if (r < 55)      press($urandom_range(0, 9));
      else if (r < 80)      press($urandom_range(10, 12));
      else if (r < 88)      press(13);
      else if (r < 94)      press(14);
      else                  press(15);
    end

    // reset in the middle of a multiply, with the key held across release
    press(15);
    press_seq('{1, 2, 12, 3});
    @(negedge clk); value = 4'd13; intro = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("mid_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_num", int'(num), 0);
    check_eq("arst_conv", int'(convert), 0);
    check_eq("arst_err", int'(error), 0);
    repeat (3) @(negedge clk);
    model_reset();
    exp_q.push_back('0);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    intro = 1'b0;
    repeat (4) @(negedge clk);
    compare_q("rst_mid");
    press(4);
    check_eq("after_rst", int'(num), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
